// File: rtl/axis_up_shift.sv
// axis_up_shift: packs S narrow AXI4-Stream beats into one wide beat, lane 0 first.
// Early tlast flushes a zero-padded partial beat with tkeep marking the filled lanes.
module axis_up_shift #(
    parameter int N = 4,
    parameter int S = 4,
    parameter int I = 1,
    parameter int D = 1,
    parameter int U = 1
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic               axis_in_tvalid_i,
    output logic               axis_in_tready_o,
    input  logic [8*N/S-1:0]   axis_in_tdata_i,
    input  logic               axis_in_tlast_i,
    input  logic [I-1:0]       axis_in_tid_i,
    input  logic [D-1:0]       axis_in_tdest_i,
    input  logic [U-1:0]       axis_in_tuser_i,
    output logic               axis_out_tvalid_o,
    input  logic               axis_out_tready_i,
    output logic [8*N-1:0]     axis_out_tdata_o,
    output logic [N-1:0]       axis_out_tkeep_o,
    output logic               axis_out_tlast_o,
    output logic [I-1:0]       axis_out_tid_o,
    output logic [D-1:0]       axis_out_tdest_o,
    output logic [U-1:0]       axis_out_tuser_o
);
    localparam int W  = N / S;
    localparam int NI = 8 * W;
    localparam int IW = $clog2(S);

    if (S < 2 || N % S != 0) begin : g_bad_params
        $fatal(1, "axis_up_shift: S must exceed 1 and divide N");
    end

    logic [IW-1:0]  idx_q, idx_d;
    logic [8*N-1:0] acc_q, acc_d, beat_w;
    logic [I-1:0]   tid_q, tid_d;
    logic [D-1:0]   tdest_q, tdest_d;
    logic [U-1:0]   tuser_q, tuser_d;
    logic           ovalid_q, ovalid_d, olast_q, olast_d;
    logic [8*N-1:0] odata_q, odata_d;
    logic [N-1:0]   okeep_q, okeep_d;
    logic [I-1:0]   otid_q, otid_d;
    logic [D-1:0]   odest_q, odest_d;
    logic [U-1:0]   ouser_q, ouser_d;
    logic           first, complete, fire, load;

    // Only the completing beat depends on the output register having room.
    always_comb begin
        first    = idx_q == '0;
        complete = idx_q == IW'(S - 1) || axis_in_tlast_i;
        axis_in_tready_o = ~areset & (~complete | ~ovalid_q | axis_out_tready_i);
        fire     = axis_in_tvalid_i & axis_in_tready_o;
        load     = fire & complete;
        beat_w   = {{(8*N-NI){1'b0}}, axis_in_tdata_i} << (NI * int'(idx_q));
        idx_d    = load ? '0 : fire ? idx_q + 1'b1 : idx_q;
        acc_d    = load ? '0 : fire ? acc_q | beat_w : acc_q;
        tid_d    = fire & first ? axis_in_tid_i : tid_q;
        tdest_d  = fire & first ? axis_in_tdest_i : tdest_q;
        tuser_d  = load ? '0 : fire ? tuser_q | axis_in_tuser_i : tuser_q;
        ovalid_d = load | (ovalid_q & ~axis_out_tready_i);
        odata_d  = load ? acc_q | beat_w : odata_q;
        okeep_d  = load ? ~({N{1'b1}} << (W * (int'(idx_q) + 1))) : okeep_q;
        olast_d  = load ? axis_in_tlast_i : olast_q;
        otid_d   = load ? (first ? axis_in_tid_i : tid_q) : otid_q;
        odest_d  = load ? (first ? axis_in_tdest_i : tdest_q) : odest_q;
        ouser_d  = load ? tuser_q | axis_in_tuser_i : ouser_q;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            idx_q    <= '0;
            acc_q    <= '0;
            tid_q    <= '0;
            tdest_q  <= '0;
            tuser_q  <= '0;
            ovalid_q <= 1'b0;
            odata_q  <= '0;
            okeep_q  <= '0;
            olast_q  <= 1'b0;
            otid_q   <= '0;
            odest_q  <= '0;
            ouser_q  <= '0;
        end else begin
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            tid_q    <= tid_d;
            tdest_q  <= tdest_d;
            tuser_q  <= tuser_d;
            ovalid_q <= ovalid_d;
            odata_q  <= odata_d;
            okeep_q  <= okeep_d;
            olast_q  <= olast_d;
            otid_q   <= otid_d;
            odest_q  <= odest_d;
            ouser_q  <= ouser_d;
        end
    end

    assign axis_out_tvalid_o = ovalid_q;
    assign axis_out_tdata_o  = odata_q;
    assign axis_out_tkeep_o  = okeep_q;
    assign axis_out_tlast_o  = olast_q;
    assign axis_out_tid_o    = otid_q;
    assign axis_out_tdest_o  = odest_q;
    assign axis_out_tuser_o  = ouser_q;
endmodule

// File: tb/tb_axis_up_shift.sv
// tb_axis_up_shift: directed and random stimulus against a queue-based packing model.
module tb_axis_up_shift;
    localparam int N = 4, S = 4, I = 4, D = 2, U = 1;
    localparam int W = N / S, NI = 8 * W;

    typedef struct {
        logic [8*N-1:0] d;
        logic [N-1:0]   k;
        logic           l;
        logic [I-1:0]   id;
        logic [D-1:0]   de;
        logic [U-1:0]   u;
    } beat_t;

    logic aclk = 1'b0, areset = 1'b1;
    logic in_tvalid = 1'b0, in_tready, in_tlast = 1'b0;
    logic [NI-1:0] in_tdata = '0;
    logic [I-1:0] in_tid = '0;
    logic [D-1:0] in_tdest = '0;
    logic [U-1:0] in_tuser = '0;
    logic out_tvalid, otr = 1'b1, out_tlast;
    logic [8*N-1:0] out_tdata;
    logic [N-1:0] out_tkeep;
    logic [I-1:0] out_tid;
    logic [D-1:0] out_tdest;
    logic [U-1:0] out_tuser;

    always #5 aclk = ~aclk;

    axis_up_shift #(.N(N), .S(S), .I(I), .D(D), .U(U)) dut (
        .aclk(aclk), .areset(areset),
        .axis_in_tvalid_i(in_tvalid), .axis_in_tready_o(in_tready),
        .axis_in_tdata_i(in_tdata), .axis_in_tlast_i(in_tlast),
        .axis_in_tid_i(in_tid), .axis_in_tdest_i(in_tdest), .axis_in_tuser_i(in_tuser),
        .axis_out_tvalid_o(out_tvalid), .axis_out_tready_i(otr),
        .axis_out_tdata_o(out_tdata), .axis_out_tkeep_o(out_tkeep), .axis_out_tlast_o(out_tlast),
        .axis_out_tid_o(out_tid), .axis_out_tdest_o(out_tdest), .axis_out_tuser_o(out_tuser)
    );

    int checks = 0, errors = 0;
    int in_acc_cnt = 0, out_cnt = 0, stall_cnt = 0;
    bit last_fire = 1'b0;
    beat_t exp_q[$], cap_q[$], b, c;
    logic [NI-1:0] g_d[$];
    logic [I-1:0] g_id;
    logic [D-1:0] g_de;
    logic [U-1:0] g_u;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: accepted narrow beats collect in g_d; a full or tlast-ended group becomes one expected wide beat.
    always @(negedge aclk) begin
        chk("in_tready", in_tready,
            !areset && !((g_d.size() == S - 1 || in_tlast) && exp_q.size() != 0 && !otr));
        chk("out_tvalid", out_tvalid, exp_q.size() != 0);
        if (exp_q.size() != 0 && out_tvalid) begin
            chk("out_tdata", out_tdata, exp_q[0].d);
            chk("out_tkeep", out_tkeep, exp_q[0].k);
            chk("out_tlast", out_tlast, exp_q[0].l);
            chk("out_tid", out_tid, exp_q[0].id);
            chk("out_tdest", out_tdest, exp_q[0].de);
            chk("out_tuser", out_tuser, exp_q[0].u);
        end
        if (areset) begin
            exp_q.delete();
            g_d.delete();
        end else begin
            if (out_tvalid && otr) begin
                c = '{out_tdata, out_tkeep, out_tlast, out_tid, out_tdest, out_tuser};
                cap_q.push_back(c);
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                out_cnt++;
            end
            if (in_tvalid && !in_tready) stall_cnt++;
            if (in_tvalid && in_tready) begin
                in_acc_cnt++;
                if (g_d.size() == 0) begin
                    g_id = in_tid;
                    g_de = in_tdest;
                    g_u  = '0;
                end
                g_d.push_back(in_tdata);
                g_u = g_u | in_tuser;
                if (g_d.size() == S || in_tlast) begin
                    b.d = '0;
                    b.k = '0;
                    for (int k = 0; k < g_d.size(); k++) begin
                        b.d = b.d | ((8*N)'(g_d[k]) << (k * NI));
                        for (int j = 0; j < W; j++) b.k[k*W+j] = 1'b1;
                    end
                    b.l = in_tlast;
                    b.id = g_id;
                    b.de = g_de;
                    b.u = g_u;
                    exp_q.push_back(b);
                    g_d.delete();
                end
            end
        end
        last_fire = in_tvalid && in_tready;
    end

    task automatic beat(input logic [NI-1:0] d, input bit l,
                        input logic [I-1:0] id = '0, input logic [U-1:0] u = '0);
        in_tvalid = 1'b1;
        in_tdata = d;
        in_tlast = l;
        in_tid = id;
        in_tdest = d[D-1:0];
        in_tuser = u;
        for (int n = 0; ; n++) begin
            @(negedge aclk);
            if (in_tready) break;
            if (n >= 200) begin
                checks++;
                errors++;
                $display("FAIL beat_timeout: data %0h never accepted within %0d cycles", d, n);
                break;
            end
        end
        @(posedge aclk);
        #1;
        in_tvalid = 1'b0;
    endtask

    task automatic chk_beat(input string nm, input int idx, input logic [8*N-1:0] d,
                            input logic [N-1:0] k, input bit l);
        if (cap_q.size() <= idx) begin
            checks++;
            errors++;
            $display("FAIL %s: only %0d beats seen, required beat %0d", nm, cap_q.size(), idx);
        end else begin
            chk({nm, "_data"}, cap_q[idx].d, d);
            chk({nm, "_keep"}, cap_q[idx].k, k);
            chk({nm, "_last"}, cap_q[idx].l, l);
        end
    endtask

    initial begin
        int base, sbase, obase;
        time t0;
        repeat (3) @(posedge aclk);
        #1;
        chk("reset_tdata", out_tdata, 0);
        chk("reset_tkeep", out_tkeep, 0);
        chk("reset_tvalid", out_tvalid, 0);
        areset = 1'b0;

        cap_q.delete();
        beat(8'h11, 0); beat(8'h22, 0); beat(8'h33, 0); beat(8'h44, 1);
        chk("t1_latency", out_tvalid, 1);
        repeat (2) @(posedge aclk);
        #1;
        chk("t1_count", cap_q.size(), 1);
        chk_beat("t1", 0, 32'h44332211, 4'hF, 1);

        cap_q.delete();
        beat(8'hAA, 0); beat(8'hBB, 1);
        for (int i = 1; i <= 4; i++) beat(8'(i), 0);
        repeat (2) @(posedge aclk);
        #1;
        chk_beat("t2a", 0, 32'h0000BBAA, 4'h3, 1);
        chk_beat("t2b", 1, 32'h04030201, 4'hF, 0);

        cap_q.delete();
        otr = 1'b0;
        base = in_acc_cnt;
        fork
            for (int i = 1; i <= 8; i++) beat(8'(i), 0);
            begin
                repeat (20) @(posedge aclk);
                #1;
                chk("t3_accepted", in_acc_cnt - base, 7);
                chk("t3_held", in_tready, 0);
                otr = 1'b1;
            end
        join
        repeat (3) @(posedge aclk);
        #1;
        chk("t3_count", cap_q.size(), 2);
        chk_beat("t3a", 0, 32'h04030201, 4'hF, 0);
        chk_beat("t3b", 1, 32'h08070605, 4'hF, 0);

        sbase = stall_cnt;
        obase = out_cnt;
        t0 = $time;
        for (int i = 0; i < 64; i++) beat(8'($urandom), 0);
        chk("t4_cycles", ($time - t0) / 10, 64);
        repeat (2) @(posedge aclk);
        #1;
        chk("t4_stalls", stall_cnt - sbase, 0);
        chk("t4_out_beats", out_cnt - obase, 16);

        cap_q.delete();
        beat(8'h61, 0); beat(8'h62, 0);
        areset = 1'b1;
        @(posedge aclk);
        #1;
        areset = 1'b0;
        chk("t5_tvalid", out_tvalid, 0);
        chk("t5_tdata", out_tdata, 0);
        beat(8'h71, 0); beat(8'h72, 0); beat(8'h73, 0); beat(8'h74, 0);
        repeat (2) @(posedge aclk);
        #1;
        chk("t5_count", cap_q.size(), 1);
        chk_beat("t5", 0, 32'h74737271, 4'hF, 0);

        cap_q.delete();
        beat(8'hA0, 0, 4'd5, 1'b0); beat(8'hA1, 0, 4'd7, 1'b0);
        beat(8'hA2, 0, 4'd7, 1'b1); beat(8'hA3, 1, 4'd7, 1'b0);
        repeat (2) @(posedge aclk);
        #1;
        chk_beat("t6", 0, 32'hA3A2A1A0, 4'hF, 1);
        if (cap_q.size() > 0) begin
            chk("t6_tid", cap_q[0].id, 5);
            chk("t6_tuser", cap_q[0].u, 1);
        end

        // Random traffic: hold an unaccepted beat stable, otherwise draw a fresh one.
        for (int n = 0; n < 3000; n++) begin
            if (!(in_tvalid && !last_fire)) begin
                in_tvalid = $urandom_range(0, 3) != 0;
                in_tdata = NI'($urandom);
                in_tlast = $urandom_range(0, 6) == 0;
                in_tid = I'($urandom);
                in_tdest = D'($urandom);
                in_tuser = $urandom_range(0, 4) == 0;
            end
            otr = $urandom_range(0, 3) != 0;
            @(posedge aclk);
            #1;
        end
        in_tvalid = 1'b0;
        otr = 1'b1;
        repeat (5) @(posedge aclk);
        #1;
        chk("final_drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
